// File: rtl/alu_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// alu_dispatch_pkg
// Shared definitions for the ALU issue-side dispatcher:
//   - op-code encodings (identical to the result-mux select encoding)
//   - functional-unit count and the first multi-cycle unit index
//   - dispatcher FSM state type
//   - op_to_unit(): maps an op select onto the functional unit that runs it
// -----------------------------------------------------------------------------
package alu_dispatch_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    // 10..15 all execute on the shared compare unit
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
    // 16..19 execute on the multi-cycle units
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_MULH = 5'd17;
    localparam logic [4:0] OP_DIV  = 5'd18;
    localparam logic [4:0] OP_REM  = 5'd19;

    localparam logic [4:0] OP_ILLEGAL_MIN = 5'd20;

    localparam int         NUM_UNITS        = 15;
    localparam logic [3:0] FIRST_MULTI_UNIT = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // Illegal ops return unit 0; callers must gate the start with is_illegal.
    function automatic logic [3:0] op_to_unit(input logic [4:0] op);
        logic [3:0] unit;
        if (op < OP_BEQ) begin
            unit = op[3:0];
        end else if (op < OP_MUL) begin
            unit = 4'd10;
        end else if (op < OP_ILLEGAL_MIN) begin
            unit = FIRST_MULTI_UNIT + 4'(op - OP_MUL);
        end else begin
            unit = 4'd0;
        end
        return unit;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational op decoder for the dispatcher.
// Ports:
//   i_op         in   5  op select
//   o_unit       out  4  target functional unit index (0 for illegal ops)
//   o_is_multi   out  1  target unit is multi-cycle (units 11..14)
//   o_is_illegal out  1  op select is outside the defined range (>= 20)
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_dispatch_pkg::*;
(
    input  logic [4:0] i_op,
    output logic [3:0] o_unit,
    output logic       o_is_multi,
    output logic       o_is_illegal
);

    assign o_is_illegal = (i_op >= OP_ILLEGAL_MIN);
    assign o_is_multi   = !o_is_illegal && (i_op >= OP_MUL);
    assign o_unit       = op_to_unit(i_op);

endmodule

// File: rtl/alu_dispatch.sv
// -----------------------------------------------------------------------------
// alu_dispatch
// Issue-side dispatcher for the ALU functional units. Accepts one op over a
// valid/ready handshake, registers the operands, pulses a one-hot start to the
// target unit, waits for multi-cycle units to complete and then offers the
// matching result-mux select over a second valid/ready handshake.
//
// Optional feature (macro ALU_DISPATCH_TIMEOUT_EN): an EXEC watchdog that
// forces a response with res_timeout=1 after TIMEOUT_CYC cycles without done.
// With the macro undefined EXEC waits indefinitely and res_timeout is 0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready/in_op/in_a/in_b   op issue handshake
//   unit_start    one-hot single-cycle start pulse per functional unit
//   unit_a/unit_b registered operands, broadcast to all units
//   unit_done     completion pulses (only multi-cycle bits 11..14 matter)
//   res_valid/res_ready/res_sel/res_illegal/res_timeout  result handshake
// -----------------------------------------------------------------------------
module alu_dispatch #(
    parameter int N           = 32,
    parameter int NUM_UNITS   = 15,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_op,
    input  logic [N-1:0]         in_a,
    input  logic [N-1:0]         in_b,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [N-1:0]         unit_a,
    output logic [N-1:0]         unit_b,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4:0]           res_sel,
    output logic                 res_illegal,
    output logic                 res_timeout
);

    import alu_dispatch_pkg::*;

    if (TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("alu_dispatch: TIMEOUT_CYC must be at least 2");
    end

    state_t               r_state;
    logic [NUM_UNITS-1:0] r_start;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    logic [4:0]           r_sel;
    logic [3:0]           r_unit;
    logic                 r_res_valid;
    logic                 r_illegal;
    logic                 r_timeout;

    logic [3:0]           w_unit;
    logic                 w_is_multi;
    logic                 w_is_illegal;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_expire;
    logic [NUM_UNITS-1:0] w_onehot;

    alu_op_decode u_decode (
        .i_op         (in_op),
        .o_unit       (w_unit),
        .o_is_multi   (w_is_multi),
        .o_is_illegal (w_is_illegal)
    );

    assign in_ready = (r_state == IDLE) || ((r_state == RESP) && res_ready);
    assign w_accept = in_valid && in_ready;
    assign w_onehot = w_is_illegal ? '0 : (NUM_UNITS'(1) << w_unit);

    // The start pulse is only ever high in the first EXEC cycle, so it doubles
    // as the marker for "done seen in the start cycle must be ignored".
    assign w_done = unit_done[r_unit] && (r_start == '0);

`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds the number of EXEC cycles already completed.
    assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == EXEC) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_start     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_unit      <= '0;
            r_res_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_start <= '0;
            if (w_accept) begin
                r_a       <= in_a;
                r_b       <= in_b;
                r_sel     <= in_op;
                r_unit    <= w_unit;
                r_illegal <= w_is_illegal;
                r_timeout <= 1'b0;
                r_start   <= w_onehot;
                if (w_is_multi) begin
                    r_state     <= EXEC;
                    r_res_valid <= 1'b0;
                end else begin
                    r_state     <= RESP;
                    r_res_valid <= 1'b1;
                end
            end else begin
                case (r_state)
                    EXEC: begin
                        // done has priority over a simultaneous watchdog expiry
                        if (w_done) begin
                            r_state     <= RESP;
                            r_res_valid <= 1'b1;
                            r_timeout   <= 1'b0;
                        end else if (w_expire) begin
                            r_state     <= RESP;
                            r_res_valid <= 1'b1;
                            r_timeout   <= 1'b1;
                        end
                    end
                    RESP: begin
                        if (res_ready) begin
                            r_state     <= IDLE;
                            r_res_valid <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign unit_start  = r_start;
    assign unit_a      = r_a;
    assign unit_b      = r_b;
    assign res_valid   = r_res_valid;
    assign res_sel     = r_sel;
    assign res_illegal = r_illegal;
    assign res_timeout = r_timeout;

endmodule
